// File: rtl/mgmt_mbx_pkg.sv
// Shared definitions for the management mailbox: register offsets,
// STATUS/CTRL bit positions, bus-handshake state type and a helper
// that assembles the STATUS word.
package mgmt_mbx_pkg;

    // Register offsets, selected by byte address bits [3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int ST_M2C_FULL    = 0;
    localparam int ST_M2C_EMPTY   = 1;
    localparam int ST_C2M_FULL    = 2;
    localparam int ST_C2M_EMPTY   = 3;
    localparam int ST_M2C_OVF     = 4;
    localparam int ST_C2M_UNF     = 5;
    localparam int ST_M2C_CNT_LSB = 8;
    localparam int ST_C2M_CNT_LSB = 16;

    // CTRL bit positions
    localparam int CTRL_IRQ_EN     = 0;
    localparam int CTRL_FLUSH_M2C  = 1;
    localparam int CTRL_FLUSH_C2M  = 2;
    localparam int CTRL_CLR_STICKY = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_e;

    function automatic logic [31:0] pack_status(
        input logic       m2c_full,
        input logic       m2c_empty,
        input logic       c2m_full,
        input logic       c2m_empty,
        input logic       m2c_ovf,
        input logic       c2m_unf,
        input logic [3:0] m2c_cnt,
        input logic [3:0] c2m_cnt
    );
        logic [31:0] s;
        s = '0;
        s[ST_M2C_FULL]  = m2c_full;
        s[ST_M2C_EMPTY] = m2c_empty;
        s[ST_C2M_FULL]  = c2m_full;
        s[ST_C2M_EMPTY] = c2m_empty;
        s[ST_M2C_OVF]   = m2c_ovf;
        s[ST_C2M_UNF]   = c2m_unf;
        s[ST_M2C_CNT_LSB +: 4] = m2c_cnt;
        s[ST_C2M_CNT_LSB +: 4] = c2m_cnt;
        return s;
    endfunction

endpackage

// File: rtl/mgmt_mbx_fifo.sv
// Synchronous word FIFO used for both mailbox directions.
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (sync empty)
//   push_i/din_i   : write when not full (full sampled at start of cycle)
//   pop_i/dout_o   : advance head when not empty; dout_o is the current head
//   full_o, empty_o, count_o : occupancy
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module mbx_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       count_o
);
    logic [AW:0]       wptr_q, rptr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign count_o = wptr_q - rptr_q;
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    // A flush wins over any same-cycle push or pop.
    assign do_push = push_i & ~full_o  & ~flush_i;
    assign do_pop  = pop_i  & ~empty_o & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/mgmt_mbx.sv
// Wishbone-slave mailbox between the management SoC and the user core.
// Ports:
//   wb_clk_i, wb_rst_i (async, active-high)
//   wbs_*             : Wishbone classic slave, 16-byte window at BASE_ADDR
//   m2c_data/valid/ready : mgmt->core stream (core pops on valid & ready)
//   c2m_data/valid/ready : core->mgmt stream (core pushes on valid & ready)
//   mbx_irq           : level interrupt, registered irq_en & c2m not empty
// Every bus transaction takes two cycles: request accepted in IDLE, ack
// registered together with all side effects, then one ACK cycle back to IDLE.
module mgmt_mbx
    import mgmt_mbx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] m2c_data,
    output logic        m2c_valid,
    input  logic        m2c_ready,
    input  logic [31:0] c2m_data,
    input  logic        c2m_valid,
    output logic        c2m_ready,
    output logic        mbx_irq
);
    localparam int CW = $clog2(DEPTH) + 1;

    bus_state_e  state_q;
    logic        ack_q, irq_en_q, m2c_ovf_q, c2m_unf_q, irq_q;
    logic [31:0] dat_q, rdata_d;

    logic        in_win, req;
    logic [1:0]  reg_sel;
    logic        wr_data, rd_data, wr_ctrl;
    logic        flush_m2c, flush_c2m, clr_sticky;

    logic          m2c_full, m2c_empty, c2m_full, c2m_empty;
    logic [CW-1:0] m2c_cnt, c2m_cnt;
    logic [31:0]   c2m_dout;
    logic          m2c_pop, c2m_push;
    logic          unused_bits;

    assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0]};

    // Address decode; out-of-window accesses still complete the handshake.
    assign in_win  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_sel = wbs_adr_i[3:2];
    assign req     = wbs_stb_i & wbs_cyc_i & (state_q == ST_IDLE);

    assign wr_data = req & in_win &  wbs_we_i & (reg_sel == REG_DATA);
    assign rd_data = req & in_win & ~wbs_we_i & (reg_sel == REG_DATA);
    assign wr_ctrl = req & in_win &  wbs_we_i & (reg_sel == REG_CTRL) & wbs_sel_i[0];

    assign flush_m2c  = wr_ctrl & wbs_dat_i[CTRL_FLUSH_M2C];
    assign flush_c2m  = wr_ctrl & wbs_dat_i[CTRL_FLUSH_C2M];
    assign clr_sticky = wr_ctrl & wbs_dat_i[CTRL_CLR_STICKY];

    assign m2c_pop  = m2c_ready & ~m2c_empty;
    assign c2m_push = c2m_valid & ~c2m_full;

    mbx_fifo #(.DEPTH(DEPTH), .DATA_W(32)) u_m2c (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .flush_i (flush_m2c),
        .push_i  (wr_data),
        .pop_i   (m2c_pop),
        .din_i   (wbs_dat_i),
        .dout_o  (m2c_data),
        .full_o  (m2c_full),
        .empty_o (m2c_empty),
        .count_o (m2c_cnt)
    );

    mbx_fifo #(.DEPTH(DEPTH), .DATA_W(32)) u_c2m (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .flush_i (flush_c2m),
        .push_i  (c2m_push),
        .pop_i   (rd_data),
        .din_i   (c2m_data),
        .dout_o  (c2m_dout),
        .full_o  (c2m_full),
        .empty_o (c2m_empty),
        .count_o (c2m_cnt)
    );

    assign m2c_valid = ~m2c_empty;
    assign c2m_ready = ~c2m_full;

    // Read data as seen at the start of the accepting cycle.
    always_comb begin
        rdata_d = '0;
        if (in_win) begin
            case (reg_sel)
                REG_DATA:   rdata_d = c2m_empty ? '0 : c2m_dout;
                REG_STATUS: rdata_d = pack_status(m2c_full, m2c_empty, c2m_full, c2m_empty,
                                                  m2c_ovf_q, c2m_unf_q,
                                                  4'(m2c_cnt), 4'(c2m_cnt));
                REG_CTRL:   rdata_d = 32'(irq_en_q);
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_en_q  <= 1'b0;
            m2c_ovf_q <= 1'b0;
            c2m_unf_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            irq_q <= irq_en_q & ~c2m_empty;

            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                        dat_q   <= wbs_we_i ? '0 : rdata_d;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    dat_q   <= '0;
                end
            endcase

            // Overflow uses start-of-cycle full, so a same-cycle core pop
            // never rescues a write to a full FIFO.
            if (wr_data & m2c_full)       m2c_ovf_q <= 1'b1;
            else if (clr_sticky)          m2c_ovf_q <= 1'b0;

            if (rd_data & c2m_empty)      c2m_unf_q <= 1'b1;
            else if (clr_sticky)          c2m_unf_q <= 1'b0;

            if (wr_ctrl) irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign mbx_irq   = irq_q;

endmodule

// File: tb/tb_mgmt_mbx.sv
module tb_mgmt_mbx;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dati;
    logic        ack;
    logic [31:0] dato;
    logic [31:0] m2c_data;
    logic        m2c_valid, m2c_ready;
    logic [31:0] c2m_data;
    logic        c2m_valid, c2m_ready;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mgmt_mbx #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dati),
        .wbs_ack_o (ack),
        .wbs_dat_o (dato),
        .m2c_data  (m2c_data),
        .m2c_valid (m2c_valid),
        .m2c_ready (m2c_ready),
        .c2m_data  (c2m_data),
        .c2m_valid (c2m_valid),
        .c2m_ready (c2m_ready),
        .mbx_irq   (irq)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // One bus transaction, entered and left at posedge+1 with ack low.
    // Optionally a core pop (m2c) or core push (c2m) is presented in the
    // same cycle the request is accepted.
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic cpop, input logic cpush,
                       input logic [31:0] cdat, output logic [31:0] rd, output int lat);
        adr = a; dati = d; sel = s; we = w; stb = 1'b1; cyc = 1'b1;
        if (cpop) m2c_ready = 1'b1;
        if (cpush) begin c2m_valid = 1'b1; c2m_data = cdat; end
        lat = 0;
        rd  = '0;
        while (lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (cpop)  m2c_ready = 1'b0;
            if (cpush) c2m_valid = 1'b0;
            if (ack) break;
        end
        rd  = dato;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rd_reg(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r; int l;
        bus(1'b0, a, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, r, l);
        check({nm, " lat"}, 32'(l), 32'd1);
        check(nm, r, exp);
    endtask

    task automatic wr_reg(input string nm, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r; int l;
        bus(1'b1, a, d, s, 1'b0, 1'b0, 32'h0, r, l);
        check({nm, " lat"}, 32'(l), 32'd1);
    endtask

    task automatic core_push(input logic [31:0] d);
        c2m_valid = 1'b1; c2m_data = d;
        @(posedge clk); #1;
        c2m_valid = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add_vec(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] exp);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.s = s; v.exp = exp;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] model_status(input int nm, input int nc, input bit ovf, input bit unf);
        logic [31:0] s;
        s = 32'd0;
        if (nm == DEPTH) s = s + 32'd1;
        if (nm == 0)     s = s + 32'd2;
        if (nc == DEPTH) s = s + 32'd4;
        if (nc == 0)     s = s + 32'd8;
        if (ovf)         s = s + 32'd16;
        if (unf)         s = s + 32'd32;
        s = s + 32'(nm) * 32'd256 + 32'(nc) * 32'd65536;
        return s;
    endfunction

    // Reference model state for the randomized phase
    logic [31:0] qm[$];
    logic [31:0] qc[$];
    bit          m_en, m_ovf, m_unf, m_irq, m_ack;
    logic [31:0] m_rd;

    initial begin
        logic [31:0] r, exp_rd;
        int          l, op, nm, nc;
        bit          go, win, wd, rdd, wc, fm, fc, irq_n;
        logic [1:0]  off;

        rst = 1'b1; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; dati = 0;
        m2c_ready = 0; c2m_valid = 0; c2m_data = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        check("reset ack", 32'(ack), 32'd0);
        check("reset dat_o", dato, 32'd0);
        check("reset m2c_valid", 32'(m2c_valid), 32'd0);
        check("reset c2m_ready", 32'(c2m_ready), 32'd1);
        check("reset irq", 32'(irq), 32'd0);

        // Table-driven register vectors
        add_vec(0, BASE + 32'h4, 0,        4'hF, 32'h0000_000A);
        add_vec(1, BASE + 32'h0, 32'h11,   4'h0, 0);
        add_vec(1, BASE + 32'h0, 32'h22,   4'hF, 0);
        add_vec(1, BASE + 32'h0, 32'h33,   4'h3, 0);
        add_vec(1, BASE + 32'h0, 32'h44,   4'hF, 0);
        add_vec(0, BASE + 32'h4, 0,        4'hF, 32'h0000_0409);
        add_vec(1, BASE + 32'h0, 32'h55,   4'hF, 0);
        add_vec(0, BASE + 32'h4, 0,        4'hF, 32'h0000_0419);
        add_vec(0, BASE + 32'hC, 0,        4'hF, 32'h0);
        add_vec(0, BASE + 32'h8, 0,        4'hF, 32'h0);
        add_vec(1, BASE + 32'h8, 32'h1,    4'hF, 0);
        add_vec(0, BASE + 32'h8, 0,        4'hF, 32'h1);
        add_vec(1, BASE + 32'h8, 32'h0,    4'hE, 0);
        add_vec(0, BASE + 32'h8, 0,        4'hF, 32'h1);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].w) wr_reg($sformatf("vec%0d", i), tbl[i].a, tbl[i].d, tbl[i].s);
            else          rd_reg($sformatf("vec%0d", i), tbl[i].a, tbl[i].exp);
        end

        // Core drains m2c on consecutive cycles
        check("m2c head valid", 32'(m2c_valid), 32'd1);
        check("m2c head", m2c_data, 32'h11);
        m2c_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("m2c drain %0d", i), m2c_data, 32'(i * 32'h11));
        end
        @(posedge clk); #1;
        check("m2c drained valid", 32'(m2c_valid), 32'd0);
        m2c_ready = 1'b0;

        // c2m path with interrupt
        check("irq idle", 32'(irq), 32'd0);
        core_push(32'hA5A5_0001);
        core_push(32'hA5A5_0002);
        check("irq raised", 32'(irq), 32'd1);
        rd_reg("c2m rd1", BASE, 32'hA5A5_0001);
        rd_reg("c2m rd2", BASE, 32'hA5A5_0002);
        check("irq fell", 32'(irq), 32'd0);
        rd_reg("c2m rd empty", BASE, 32'h0);
        rd_reg("status sticky", BASE + 4, 32'h0000_003A);
        wr_reg("clr sticky", BASE + 8, 32'h9, 4'h1);
        rd_reg("status cleared", BASE + 4, 32'h0000_000A);

        // Full m2c: write dropped even with a same-cycle core pop
        for (int i = 1; i <= 4; i++) wr_reg("fill m2c", BASE, 32'h100 + 32'(i), 4'hF);
        bus(1'b1, BASE, 32'h105, 4'hF, 1'b1, 1'b0, 32'h0, r, l);
        check("wr+pop lat", 32'(l), 32'd1);
        rd_reg("status wr+pop", BASE + 4, 32'h0000_0318);
        check("m2c after pop", m2c_data, 32'h102);
        m2c_ready = 1'b1;
        @(posedge clk); #1; check("m2c order a", m2c_data, 32'h103);
        @(posedge clk); #1; check("m2c order b", m2c_data, 32'h104);
        @(posedge clk); #1; check("m2c dropped", 32'(m2c_valid), 32'd0);
        m2c_ready = 1'b0;

        // c2m: same-cycle core push and bus pop
        wr_reg("clr sticky 2", BASE + 8, 32'h9, 4'h1);
        core_push(32'hB000_0001);
        core_push(32'hB000_0002);
        bus(1'b0, BASE, 32'h0, 4'hF, 1'b0, 1'b1, 32'hB000_0003, r, l);
        check("rd+push lat", 32'(l), 32'd1);
        check("rd+push data", r, 32'hB000_0001);
        rd_reg("status rd+push", BASE + 4, 32'h0002_0002);
        rd_reg("c2m order a", BASE, 32'hB000_0002);
        rd_reg("c2m order b", BASE, 32'hB000_0003);
        rd_reg("status c2m empty", BASE + 4, 32'h0000_000A);

        // Flush both FIFOs
        wr_reg("pre flush a", BASE, 32'h201, 4'hF);
        wr_reg("pre flush b", BASE, 32'h202, 4'hF);
        core_push(32'hC000_0001);
        rd_reg("status pre flush", BASE + 4, 32'h0001_0200);
        wr_reg("flush", BASE + 8, 32'h6, 4'hF);
        rd_reg("status flushed", BASE + 4, 32'h0000_000A);
        rd_reg("ctrl after flush", BASE + 8, 32'h0);
        check("m2c_valid flushed", 32'(m2c_valid), 32'd0);

        // Sticky set and clear
        rd_reg("unf read", BASE, 32'h0);
        for (int i = 0; i < 5; i++) wr_reg("ovf fill", BASE, 32'h300 + 32'(i), 4'hF);
        rd_reg("status both sticky", BASE + 4, 32'h0000_0439);
        wr_reg("clear 0x8", BASE + 8, 32'h8, 4'hF);
        rd_reg("status sticky cleared", BASE + 4, 32'h0000_0409);
        wr_reg("flush m2c", BASE + 8, 32'h2, 4'hF);
        rd_reg("status m2c flushed", BASE + 4, 32'h0000_000A);

        // Decode: outside window and reserved register
        rd_reg("outside read", BASE + 32'h40, 32'h0);
        wr_reg("outside write", BASE + 32'h40, 32'h77, 4'hF);
        wr_reg("rsvd write", BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        rd_reg("ctrl untouched", BASE + 8, 32'h0);
        rd_reg("status untouched", BASE + 4, 32'h0000_000A);

        // Reset between request and ack
        wr_reg("pre rst en", BASE + 8, 32'h1, 4'hF);
        wr_reg("pre rst data", BASE, 32'h401, 4'hF);
        core_push(32'hD000_0001);
        adr = BASE; dati = 32'h402; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        #3 rst = 1'b1;
        #1 check("rst mid ack", 32'(ack), 32'd0);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("rst mid ack 2", 32'(ack), 32'd0);
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        check("rst mid m2c_valid", 32'(m2c_valid), 32'd0);
        check("rst mid c2m_ready", 32'(c2m_ready), 32'd1);
        check("rst mid irq", 32'(irq), 32'd0);
        rd_reg("rst mid status", BASE + 4, 32'h0000_000A);
        rd_reg("rst mid ctrl", BASE + 8, 32'h0);

        // Randomized traffic against a queue-based reference model
        qm.delete(); qc.delete();
        m_en = 0; m_ovf = 0; m_unf = 0; m_irq = 0; m_ack = 0; m_rd = 0;
        for (int c = 0; c < 3000; c++) begin
            check("rnd ack", 32'(ack), 32'(m_ack));
            check("rnd dat_o", dato, m_ack ? m_rd : 32'h0);
            check("rnd m2c_valid", 32'(m2c_valid), 32'(qm.size() != 0));
            if (qm.size() != 0) check("rnd m2c_data", m2c_data, qm[0]);
            check("rnd c2m_ready", 32'(c2m_ready), 32'(qc.size() < DEPTH));
            check("rnd irq", 32'(irq), 32'(m_irq));

            m2c_ready = ($urandom_range(0, 1) == 1);
            c2m_valid = ($urandom_range(0, 1) == 1);
            c2m_data  = $urandom;
            go = !m_ack && ($urandom_range(0, 2) == 0);
            op = $urandom_range(0, 9);
            sel  = 4'($urandom);
            dati = $urandom;
            we   = 1'b0;
            adr  = BASE;
            case (op)
                0, 1, 2: begin we = 1'b1; adr = BASE; end
                3, 4:    adr = BASE;
                5:       adr = BASE + 4;
                6: begin
                    we = 1'b1; adr = BASE + 8;
                    dati = {28'd0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                            ($urandom_range(0, 7) == 0), 1'($urandom)};
                end
                7:       adr = BASE + 8;
                8: begin we = 1'($urandom); adr = BASE + 32'hC; end
                default: begin
                    we  = 1'($urandom);
                    adr = ($urandom_range(0, 1) == 1) ? BASE + 32'h40 : 32'h2000_0000;
                end
            endcase
            stb = go; cyc = go;

            @(posedge clk);
            nm  = qm.size();
            nc  = qc.size();
            win = (adr[31:4] == BASE[31:4]);
            off = adr[3:2];
            wd  = go && win && we && off == 2'd0;
            rdd = go && win && !we && off == 2'd0;
            wc  = go && win && we && off == 2'd2 && sel[0];
            fm  = wc && dati[1];
            fc  = wc && dati[2];
            exp_rd = 32'h0;
            if (go && win && !we) begin
                if (off == 2'd0)      exp_rd = (nc != 0) ? qc[0] : 32'h0;
                else if (off == 2'd1) exp_rd = model_status(nm, nc, m_ovf, m_unf);
                else if (off == 2'd2) exp_rd = m_en ? 32'h1 : 32'h0;
            end
            irq_n = m_en && (nc != 0);
            if (fm) qm.delete();
            else begin
                if (wd && nm == DEPTH) m_ovf = 1;
                if (m2c_ready && nm != 0) void'(qm.pop_front());
                if (wd && nm != DEPTH) qm.push_back(dati);
            end
            if (fc) qc.delete();
            else begin
                if (rdd && nc == 0) m_unf = 1;
                if (rdd && nc != 0) void'(qc.pop_front());
                if (c2m_valid && nc != DEPTH) qc.push_back(c2m_data);
            end
            if (wc) begin
                m_en = dati[0];
                if (dati[3]) begin m_ovf = 0; m_unf = 0; end
            end
            m_irq = irq_n;
            m_ack = go;
            m_rd  = exp_rd;
            #1;
        end
        stb = 0; cyc = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
